// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 divider (binary32/binary64): one restoring quotient bit per cycle,
// RNE rounding, DAZ/FTZ, special-value handling and exception flags; one op in flight.
module fdiv_seq #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [4:0]   flags
);
    localparam int unsigned EXP_W = (N == 64) ? 11 : 8;
    localparam int unsigned MAN_W = (N == 64) ? 52 : 23;
    localparam int unsigned Q     = MAN_W + 3;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned CNT_W = $clog2(Q + 1);
    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX  = (1 << EXP_W) - 1;
    localparam logic signed [EW-1:0] E_MAX = EW'(EMAX);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    if (N != 32 && N != 64) begin : g_bad_n
        $error("fdiv_seq: N must be 32 or 64");
    end

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [MAN_W+1:0]       rem;
    logic [MAN_W:0]         dvs;
    logic [Q-1:0]           quo;
    logic signed [EW-1:0]   exp_r;
    logic                   sign_r;
    logic                   special_r;

    // Operand unpack and classification (subnormals read as zero)
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn;
    logic             sp_hit;
    logic [N-1:0]     sp_out;
    logic [4:0]       sp_flags;
    logic [EW-1:0]    exp_in;

    always_comb begin
        ea       = a[N-2:MAN_W];
        eb       = b[N-2:MAN_W];
        fa       = a[MAN_W-1:0];
        fb       = b[MAN_W-1:0];
        sgn      = a[N-1] ^ b[N-1];
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        a_inf    = (&ea) && (fa == '0);
        b_inf    = (&eb) && (fb == '0);
        a_nan    = (&ea) && (fa != '0);
        b_nan    = (&eb) && (fb != '0);
        sp_hit   = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
        exp_in   = EW'(ea) - EW'(eb) + EW'(BIAS);
        sp_out   = {sgn, {(N-1){1'b0}}};
        sp_flags = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_out   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            sp_flags = 5'b10000;
        end else if (b_zero && !a_inf) begin
            sp_out   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_flags = 5'b01000;
        end else if (a_inf) begin
            sp_out   = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // One restoring step: quotient bit is the absence of a borrow
    logic [MAN_W+2:0] diff;
    logic             no_borrow;
    logic [MAN_W+1:0] rem_nx;

    always_comb begin
        diff      = {1'b0, rem} - {2'b00, dvs};
        no_borrow = ~diff[MAN_W+2];
        rem_nx    = (no_borrow ? diff[MAN_W+1:0] : rem) << 1;
    end

    // Normalise, round to nearest even, range check
    logic                 int_b, guard, sticky, round_up, inexact;
    logic [MAN_W-1:0]     frac, frac_out;
    logic [MAN_W+1:0]     mant;
    logic signed [EW-1:0] e_n;
    logic [N-1:0]         norm_out;
    logic [4:0]           norm_flags;

    always_comb begin
        int_b = quo[Q-1];
        if (int_b) begin
            frac   = quo[Q-2:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
        end else begin
            frac   = quo[Q-3:1];
            guard  = quo[0];
            sticky = |rem;
        end
        round_up   = guard & (sticky | frac[0]);
        inexact    = guard | sticky;
        mant       = {2'b01, frac} + (MAN_W+2)'(round_up);
        frac_out   = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
        e_n        = exp_r - EW'(!int_b) + EW'(mant[MAN_W+1]);
        norm_out   = {sign_r, e_n[EXP_W-1:0], frac_out};
        norm_flags = {4'b0000, inexact};
        if (e_n >= E_MAX) begin
            norm_out   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_flags = 5'b00101;
        end else if (e_n <= E_ZERO) begin
            norm_out   = {sign_r, {(N-1){1'b0}}};
            norm_flags = 5'b00011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
            cnt       <= '0;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            exp_r     <= '0;
            sign_r    <= 1'b0;
            special_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready  <= 1'b0;
                        sign_r    <= sgn;
                        special_r <= sp_hit;
                        exp_r     <= exp_in;
                        rem       <= {2'b01, fa};
                        dvs       <= {1'b1, fb};
                        quo       <= '0;
                        cnt       <= CNT_W'(Q);
                        if (sp_hit) begin
                            out   <= sp_out;
                            flags <= sp_flags;
                            state <= NORM;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[Q-2:0], no_borrow};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= NORM;
                end
                NORM: begin
                    if (!special_r) begin
                        out   <= norm_out;
                        flags <= norm_flags;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: vector table for binary32, plus backpressure,
// mid-division reset and a binary64 instance.
module tb_fdiv_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic [4:0]  flags;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] a64, b64, out64;
    logic [4:0]  flags64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fdiv_seq #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags)
    );

    fdiv_seq #(.N(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64),
        .out(out64), .flags(flags64)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic [4:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Issue one binary32 op, measure accept-to-out_valid latency in edges, then consume it
    task automatic run32(input logic [31:0] va, input logic [31:0] vb,
                         output logic [31:0] o, output logic [4:0] f, output int lat);
        int n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        o = out; f = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] o;
        logic [4:0]  f;
        int          lat;

        vecs.push_back('{"6div2",     32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28});
        vecs.push_back('{"1div3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28});
        vecs.push_back('{"2div3",     32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001, 28});
        vecs.push_back('{"neg6div2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28});
        vecs.push_back('{"1div1",     32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28});
        vecs.push_back('{"1div0",     32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2});
        vecs.push_back('{"0div0",     32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2});
        vecs.push_back('{"ninfdiv2",  32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2});
        vecs.push_back('{"nandiv1",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2});
        vecs.push_back('{"infdivinf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 2});
        vecs.push_back('{"1divinf",   32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 2});
        vecs.push_back('{"n0div2",    32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2});
        vecs.push_back('{"subdiv1",   32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 2});
        vecs.push_back('{"overflow",  32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28});
        vecs.push_back('{"underflow", 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; a64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);

        foreach (vecs[i]) begin
            run32(vecs[i].a, vecs[i].b, o, f, lat);
            check({vecs[i].name, "_out"}, 64'(o), 64'(vecs[i].exp_out));
            check({vecs[i].name, "_flags"}, 64'(f), 64'(vecs[i].exp_flags));
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Backpressure: result held, new requests ignored while DONE
        begin
            int n = 0;
            a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
            @(posedge clk); #1;
            a = 32'h3F800000; b = 32'h00000000;
            while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
            check("bp_reached_done", 64'(out_valid), 64'd1);
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                check("bp_out", 64'(out), 64'h40400000);
                check("bp_flags", 64'(flags), 64'd0);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp_release_valid", 64'(out_valid), 64'd0);
            check("bp_release_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
            check("bp_next_out", 64'(out), 64'h7F800000);
            check("bp_next_flags", 64'(flags), 64'b01000);
            check("bp_next_lat", 64'(lat), 64'd2);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        // Reset in the middle of an iteration
        begin
            int n = 0;
            while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
            a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (10) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            check("mid_rst_in_ready", 64'(in_ready), 64'd1);
            check("mid_rst_out_valid", 64'(out_valid), 64'd0);
            check("mid_rst_out", 64'(out), 64'd0);
            check("mid_rst_flags", 64'(flags), 64'd0);
            run32(32'h3F800000, 32'h40400000, o, f, lat);
            check("post_rst_out", 64'(o), 64'h3EAAAAAB);
            check("post_rst_flags", 64'(f), 64'b00001);
            check("post_rst_lat", 64'(lat), 64'd28);
        end

        // binary64 instance: 1/3
        begin
            int n = 0;
            while (!in_ready64 && n < 200) begin @(posedge clk); #1; n++; end
            a64 = 64'h3FF0000000000000; b64 = 64'h4008000000000000; in_valid64 = 1'b1;
            @(posedge clk); #1;
            in_valid64 = 1'b0;
            lat = 1;
            while (!out_valid64 && lat < 200) begin @(posedge clk); #1; lat++; end
            check("d64_out", out64, 64'h3FD5555555555555);
            check("d64_flags", 64'(flags64), 64'b00001);
            check("d64_lat", 64'(lat), 64'd57);
            out_ready64 = 1'b1;
            @(posedge clk); #1;
            out_ready64 = 1'b0;
            check("d64_idle", 64'(in_ready64), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Iterative, handshaked IEEE-754 floating-point divider; sequential successor to the combinational single-precision divider.
- Parametrised for binary32 or binary64.
- Computes one quotient bit per cycle with a restoring-division datapath.
- Provides RNE rounding, special-value handling and exception flags.
- Sits behind the FPU issue stage; one operation in flight.

Parameters:
- N, 32, operand width; legal values 32 or 64 only (elaboration error otherwise).
- EXP_W, derived: 8 if N=32, 11 if N=64; exponent field width.
- MAN_W, derived: 23 if N=32, 52 if N=64; stored fraction width.
- Q, derived: MAN_W+3; quotient bits produced (integer, fraction, guard, round).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle, can accept
- a  in  N  dividend
- b  in  N  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  N  quotient
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, out=0, flags=0. Reset overrides everything, including mid-division; the in-flight operation is discarded.
- States: IDLE -> DIV -> NORM -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid&in_ready, latch a and b, unpack, and classify.
  - Special operand -> NORM (skip DIV).
  - Otherwise -> DIV with quotient counter = Q.
- DIV: in_ready=0. Each cycle: trial subtract of the divisor mantissa {1,fb} from the partial remainder; quotient bit = no-borrow; remainder shifts left; counter decrements. -> NORM when the counter reaches 1.
- NORM (1 cycle):
  - If quotient integer bit = 0, shift the quotient left by 1 and subtract 1 from the exponent.
  - Sticky = OR of dropped bits and (remainder != 0).
  - Round to nearest even; a mantissa carry-out increments the exponent.
  - Register out/flags, then -> DONE.
- DONE: out_valid=1; out and flags held stable until out_ready. On out_valid&out_ready -> IDLE; out_valid falls the next cycle. in_ready stays 0 in DONE (no back-to-back overlap).
- Latency, from the accept edge to out_valid high:
  - Normal operands: Q+2 edges (28 for N=32, 57 for N=64).
  - Special operands: 2 edges.
- Exponent arithmetic: computed in EXP_W+2 bits signed; e = ea - eb + BIAS, where BIAS = 2^(EXP_W-1)-1.
  - e >= 2^EXP_W-1 after rounding -> signed infinity; set overflow and inexact.
  - e <= 0 -> signed zero (flush-to-zero); set underflow and inexact.
- Subnormal inputs are treated as zero (DAZ). Sign is always a[N-1]^b[N-1], except for NaN results.
- Special-case priority:
  1. Either operand NaN, 0/0, or inf/inf -> canonical qNaN (exp all 1, fraction MSB 1, sign 0); invalid=1.
  2. Finite nonzero / 0 -> signed inf; div_by_zero=1.
  3. inf / finite -> signed inf, no flags.
  4. finite / inf or 0 / nonzero -> signed zero, no flags.
- inexact = guard|sticky for normal results.
- in_valid asserted while in_ready=0 is ignored; the source must hold it.
- Changes on a/b after the accept edge have no effect.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> out=0x40400000, flags=0, out_valid exactly 28 edges after accept.
- 0x3F800000 / 0x40400000 (1/3) -> out=0x3EAAAAAB, flags=00001 (inexact); N=64 instance: 0x3FF0000000000000 / 0x4008000000000000 -> 0x3FD5555555555555, inexact, latency 57.
- Specials: 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero, latency 2; 0/0 -> 0x7FC00000, invalid; 0xFF800000 / 0x40000000 -> 0xFF800000, flags=0.
- Range limits: 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow+inexact; 0x00800000 / 0x40000000 -> 0x00000000, underflow+inexact.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out/flags stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle, next op accepted.
- Reset mid-DIV: drop rst_n for 1 cycle at iteration 10 -> next cycle in_ready=1, out_valid=0, out=0, flags=0; a new op then completes correctly.
